macro_pc_tracker: RTL and testbench

Parametrised shadow pipeline that tracks PC, branch-delay (BD) flag and exception status for every pipeline stage. Combinationally reports the macro PC/BD of the oldest valid in-flight instruction. Contains a small exception-entry state machine that captures EPC, cause and BD for CP0. Sits beside the datapath pipeline registers and feeds CP0 and the hazard/flush logic.

---
 rtl/macro_pc_pkg.sv | 36 +++
 rtl/macro_pc_tracker_stage.sv | 38 +++
 rtl/macro_pc_tracker.sv | 143 ++++++++++++++
 tb/tb_macro_pc_tracker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/macro_pc_pkg.sv
// Shared types for the macro PC tracker: FSM states, interrupt cause code and
// the per-stage shadow record.
package macro_pc_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int EXC_W_DEF = 5;

  localparam logic [EXC_W_DEF-1:0] EXC_INT = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HELD    = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic                 valid;
    logic [PC_W_DEF-1:0]  pc;
    logic                 bd;
    logic                 exc;
    logic [EXC_W_DEF-1:0] code;
  } stage_t;

  // Late exceptions only mark valid stages, and never overwrite an earlier code.
  function automatic stage_t merge_late_exc(input stage_t s, input logic late,
                                            input logic [EXC_W_DEF-1:0] late_code);
    stage_t r;
    r = s;
    if (s.valid && late && !s.exc) begin
      r.exc  = 1'b1;
      r.code = late_code;
    end
    return r;
  endfunction

endpackage

// File: rtl/macro_pc_tracker_stage.sv
// One shadow stage register. Flush and bubble both load an empty record;
// hold keeps the current record with any late exception folded in.
module pc_stage_reg
  import macro_pc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold_i,
  input  logic                 bubble_i,
  input  logic                 flush_i,
  input  logic                 late_exc_i,
  input  logic [EXC_W_DEF-1:0] late_code_i,
  input  stage_t               d_i,
  output stage_t               stage_o
);

  stage_t stage_q, stage_d;

  assign stage_o = merge_late_exc(stage_q, late_exc_i, late_code_i);

  always_comb begin
    stage_d = d_i;
    if (flush_i || bubble_i) begin
      stage_d = '0;
    end else if (hold_i) begin
      stage_d = stage_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/macro_pc_tracker.sv
// Shadow PC/BD/exception pipeline with oldest-valid macro PC reporting and an
// exception-entry FSM that captures EPC, cause and BD for CP0.
//
// state      | meaning
// ST_IDLE    | normal flow, watching for interrupts and oldest-stage faults
// ST_PENDING | interrupt requested while the pipeline is empty
// ST_HELD    | exception taken, handler active (exl=1) until eret
module macro_pc_tracker
  import macro_pc_pkg::*;
#(
  parameter int STAGES      = 4,
  parameter int HOLD_STAGES = 2,
  parameter int PC_W        = PC_W_DEF,
  parameter int EXC_W       = EXC_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [PC_W-1:0]       in_pc,
  input  logic                  in_bd,
  input  logic                  in_exc,
  input  logic [EXC_W-1:0]      in_exc_code,
  input  logic [STAGES-1:0]     stage_exc,
  input  logic [STAGES*EXC_W-1:0] stage_exc_code,
  input  logic                  stall,
  input  logic                  int_req,
  input  logic                  eret,
  output logic [PC_W-1:0]       macro_pc,
  output logic                  macro_bd,
  output logic                  exc_take,
  output logic [PC_W-1:0]       epc,
  output logic [EXC_W-1:0]      cause,
  output logic                  bd,
  output logic                  exl
);

  stage_t     fetch;
  stage_t     eff [STAGES];
  fsm_state_e state_q, state_d;
  logic       exc_take_q;
  logic [PC_W-1:0]  epc_q;
  logic [EXC_W-1:0] cause_q;
  logic       bd_q;
  logic       any_valid;
  logic       oldest_fault;
  logic       take;
  logic       take_int;

  assign fetch = {in_valid, in_pc, in_bd, in_exc, in_exc_code};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    stage_t d;
    if (i == 0) begin : g_head
      assign d = fetch;
    end else begin : g_body
      assign d = eff[i-1];
    end

    pc_stage_reg u_stage (
      .clk         (clk),
      .reset       (reset),
      .hold_i      (stall && (i < HOLD_STAGES)),
      .bubble_i    (stall && (i == HOLD_STAGES)),
      .flush_i     (exc_take_q),
      .late_exc_i  (stage_exc[i]),
      .late_code_i (stage_exc_code[i*EXC_W +: EXC_W]),
      .d_i         (d),
      .stage_o     (eff[i])
    );
  end

  // Ascending scan so the highest valid index is the one left standing.
  always_comb begin
    macro_pc  = '0;
    macro_bd  = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (eff[i].valid) begin
        macro_pc  = eff[i].pc;
        macro_bd  = eff[i].bd;
        any_valid = 1'b1;
      end
    end
  end

  assign oldest_fault = eff[STAGES-1].valid && eff[STAGES-1].exc;

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    take_int = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (int_req && any_valid) begin
          take     = 1'b1;
          take_int = 1'b1;
        end else if (int_req) begin
          state_d = ST_PENDING;
        end else if (oldest_fault) begin
          take = 1'b1;
        end
      end
      ST_PENDING: begin
        if (!int_req) begin
          state_d = ST_IDLE;
        end else if (any_valid) begin
          take     = 1'b1;
          take_int = 1'b1;
        end
      end
      ST_HELD: begin
        if (eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) state_d = ST_HELD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      exc_take_q <= 1'b0;
      epc_q      <= '0;
      cause_q    <= '0;
      bd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      exc_take_q <= take;
      if (take) begin
        epc_q   <= macro_bd ? macro_pc - PC_W'(4) : macro_pc;
        cause_q <= take_int ? EXC_INT : eff[STAGES-1].code;
        bd_q    <= macro_bd;
      end
    end
  end

  assign exc_take = exc_take_q;
  assign epc      = epc_q;
  assign cause    = cause_q;
  assign bd       = bd_q;
  assign exl      = (state_q == ST_HELD);

endmodule

// File: tb/tb_macro_pc_tracker.sv
// Directed bench for macro_pc_tracker: pipeline tracking, exception and
// interrupt capture, stall bubbles, eret/fault ordering and reset from HELD.
module tb_macro_pc_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic        in_bd;
  logic        in_exc;
  logic [4:0]  in_exc_code;
  logic [3:0]  stage_exc;
  logic [19:0] stage_exc_code;
  logic        stall;
  logic        int_req;
  logic        eret;
  logic [31:0] macro_pc;
  logic        macro_bd;
  logic        exc_take;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic        bd;
  logic        exl;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  macro_pc_tracker dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_bd          (in_bd),
    .in_exc         (in_exc),
    .in_exc_code    (in_exc_code),
    .stage_exc      (stage_exc),
    .stage_exc_code (stage_exc_code),
    .stall          (stall),
    .int_req        (int_req),
    .eret           (eret),
    .macro_pc       (macro_pc),
    .macro_bd       (macro_bd),
    .exc_take       (exc_take),
    .epc            (epc),
    .cause          (cause),
    .bd             (bd),
    .exl            (exl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_bd = 1'b0; in_exc = 1'b0;
    in_exc_code = '0; stage_exc = '0; stage_exc_code = '0; stall = 1'b0;
    int_req = 1'b0; eret = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_macro_pc", macro_pc, 0);
    check("rst_macro_bd", macro_bd, 0);
    check("rst_exc_take", exc_take, 0);
    check("rst_epc", epc, 0);
    check("rst_cause", cause, 0);
    check("rst_bd", bd, 0);
    check("rst_exl", exl, 0);
    check("rst_state", dut.state_q, S_IDLE);

    // Three consecutive fetches flow through to the oldest stage.
    in_valid = 1'b1; in_pc = 32'h3000;
    #1 check("t1_pre_macro_pc", macro_pc, 0);
    step(); check("t1_s0_macro_pc", macro_pc, 32'h3000);
    in_pc = 32'h3004; step();
    in_pc = 32'h3008; step();
    in_valid = 1'b0; step();
    check("t1_s3_macro_pc", macro_pc, 32'h3000);
    check("t1_s3_valid", dut.eff[3].valid, 1);
    check("t1_exc_take", exc_take, 0);
    step(); check("t1_adv_macro_pc", macro_pc, 32'h3004);
    step(); step();
    check("t1_drain_macro_pc", macro_pc, 0);
    check("t1_drain_exc_take", exc_take, 0);

    // Fetch exception in a delay slot, followed by more fetches.
    in_valid = 1'b1; in_pc = 32'h3010; in_bd = 1'b1; in_exc = 1'b1; in_exc_code = 5'd4;
    step();
    in_bd = 1'b0; in_exc = 1'b0; in_exc_code = '0; in_pc = 32'h3014; step();
    in_pc = 32'h3018; step();
    in_pc = 32'h301C; step();
    check("t2_s3_macro_pc", macro_pc, 32'h3010);
    check("t2_s3_macro_bd", macro_bd, 1);
    check("t2_pre_take", exc_take, 0);
    in_pc = 32'h3020; step();
    check("t2_exc_take", exc_take, 1);
    check("t2_epc", epc, 32'h300C);
    check("t2_bd", bd, 1);
    check("t2_cause", cause, 4);
    check("t2_exl", exl, 1);
    check("t2_state", dut.state_q, S_HELD);
    in_pc = 32'h3024; step();
    in_valid = 1'b0;
    check("t2_flush_take_low", exc_take, 0);
    check("t2_flush_v0", dut.eff[0].valid, 0);
    check("t2_flush_v1", dut.eff[1].valid, 0);
    check("t2_flush_v2", dut.eff[2].valid, 0);
    check("t2_flush_v3", dut.eff[3].valid, 0);
    check("t2_flush_macro_pc", macro_pc, 0);
    eret = 1'b1; step(); eret = 1'b0;
    check("t2_eret_exl", exl, 0);
    check("t2_eret_state", dut.state_q, S_IDLE);

    eret = 1'b1; step(); eret = 1'b0;
    check("eret_idle_state", dut.state_q, S_IDLE);
    check("eret_idle_exl", exl, 0);

    // Interrupt with an empty pipeline waits in PENDING.
    int_req = 1'b1; step();
    check("t3_pend1", dut.state_q, S_PEND);
    check("t3_pend_take", exc_take, 0);
    step(); check("t3_pend2", dut.state_q, S_PEND);
    in_valid = 1'b1; in_pc = 32'h4000; step(); in_valid = 1'b0;
    check("t3_pend3", dut.state_q, S_PEND);
    step();
    check("t3_exc_take", exc_take, 1);
    check("t3_epc", epc, 32'h4000);
    check("t3_cause", cause, 0);
    check("t3_bd", bd, 0);
    check("t3_state", dut.state_q, S_HELD);
    int_req = 1'b0; step();
    eret = 1'b1; step(); eret = 1'b0;
    check("t3_eret_state", dut.state_q, S_IDLE);

    int_req = 1'b1; step(); check("pend_abort_a", dut.state_q, S_PEND);
    int_req = 1'b0; step(); check("pend_abort_b", dut.state_q, S_IDLE);
    check("pend_abort_take", exc_take, 0);

    // Stall for three cycles with a full pipeline.
    in_valid = 1'b1;
    in_pc = 32'h5000; step();
    in_pc = 32'h5004; step();
    in_pc = 32'h5008; step();
    in_pc = 32'h500C; step();
    check("t4_full_macro_pc", macro_pc, 32'h5000);
    stall = 1'b1; in_pc = 32'h5010; step();
    check("t4_st1_s0pc", dut.eff[0].pc, 32'h500C);
    check("t4_st1_s1pc", dut.eff[1].pc, 32'h5008);
    check("t4_st1_s2v", dut.eff[2].valid, 0);
    check("t4_st1_macro_pc", macro_pc, 32'h5004);
    step();
    check("t4_st2_s3v", dut.eff[3].valid, 0);
    check("t4_st2_macro_pc", macro_pc, 32'h5008);
    step();
    check("t4_st3_s0pc", dut.eff[0].pc, 32'h500C);
    check("t4_st3_macro_pc", macro_pc, 32'h5008);
    stall = 1'b0; in_valid = 1'b0; step();
    check("t4_rel_s1pc", dut.eff[1].pc, 32'h500C);
    check("t4_rel_s2pc", dut.eff[2].pc, 32'h5008);
    check("t4_rel_macro_pc", macro_pc, 32'h5008);
    step(); check("t4_rel2_macro_pc", macro_pc, 32'h5008);
    step(); check("t4_rel3_macro_pc", macro_pc, 32'h500C);
    step(); check("t4_empty_macro_pc", macro_pc, 0);
    check("t4_no_take", exc_take, 0);

    // eret and a stage-3 fault together in HELD: return first, capture next.
    in_valid = 1'b1; in_pc = 32'h6000; step();
    int_req = 1'b1; in_pc = 32'h6004; step();
    check("t5_int_take", exc_take, 1);
    check("t5_int_epc", epc, 32'h6000);
    int_req = 1'b0; in_pc = 32'h6008; step();
    in_pc = 32'h600C; step();
    in_pc = 32'h6010; step();
    in_pc = 32'h6014; step();
    in_pc = 32'h6018; step();
    check("t5_held_s3pc", macro_pc, 32'h600C);
    eret = 1'b1; stage_exc = 4'b1000; stage_exc_code = 20'h38000; in_pc = 32'h601C;
    step();
    eret = 1'b0;
    check("t5_ret_exl", exl, 0);
    check("t5_ret_take", exc_take, 0);
    check("t5_ret_state", dut.state_q, S_IDLE);
    in_pc = 32'h6020; step();
    check("t5_fault_take", exc_take, 1);
    check("t5_fault_epc", epc, 32'h6010);
    check("t5_fault_cause", cause, 7);
    check("t5_fault_exl", exl, 1);
    stage_exc = '0; stage_exc_code = '0; in_valid = 1'b0; step();

    // Reset while HELD with epc = 0x3000 and a live pipeline.
    eret = 1'b1; step(); eret = 1'b0;
    in_valid = 1'b1; in_pc = 32'h3000; step();
    int_req = 1'b1; in_pc = 32'h3100; step();
    int_req = 1'b0;
    check("t6_epc", epc, 32'h3000);
    check("t6_exl", exl, 1);
    in_pc = 32'h3104; step();
    in_pc = 32'h3108; step();
    check("t6_live_macro_pc", macro_pc, 32'h3108);
    check("t6_live_state", dut.state_q, S_HELD);
    reset = 1'b1; in_valid = 1'b0; step(); reset = 1'b0;
    check("t6_rst_exl", exl, 0);
    check("t6_rst_epc", epc, 0);
    check("t6_rst_macro_pc", macro_pc, 0);
    check("t6_rst_state", dut.state_q, S_IDLE);
    check("t6_rst_cause", cause, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
